// File: rtl/epu_pkg.sv
// Shared types and widths for the EPU_ALG feature buffer.
package epu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } buf_state_t;

  localparam int WORD_W         = 128;
  localparam int BEAT_W         = 32;
  localparam int BEATS_PER_WORD = 4;

endpackage

// File: rtl/epu_buf_ram.sv
// DEPTH x 128 storage: one write port, one registered read port, read-before-write.
module epu_buf_ram
  import epu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] mem [2**IDX_W];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  // Out-of-range addresses and idle cycles both return zero.
  always_comb begin
    rdata_d = '0;
    if (re && ({1'b0, raddr} < DEPTH_L)) begin
      rdata_d = mem[raddr[IDX_W-1:0]];
    end else begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/epu_alg_buf.sv
// Feature buffer: packs 32-bit DMA beats into 128-bit words, fills DEPTH words,
// then pulses alg_start; EPU_ALG reads words back with one cycle of latency.
module epu_alg_buf
  import epu_pkg::*;
#(
  parameter int BLOCK_NUM = 64,
  parameter int ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic                in_valid,
  input  logic [BEAT_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                read,
  input  logic [ADDR_W-1:0]   addr,
  output logic [WORD_W-1:0]   data_read,
  output logic                alg_start,
  output logic                busy,
  output logic [ADDR_W:0]     words_done
);

  localparam int DEPTH = 16 * BLOCK_NUM;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("epu_alg_buf: DEPTH does not fit in ADDR_W");
  end

  buf_state_t          state_q, state_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W:0]     words_done_q, words_done_d;
  logic [95:0]         pack_q, pack_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                alg_start_q, alg_start_d;

  logic start_s, acc_s, word_s, last_s;

  assign start_s = load_req && (state_q != LOAD);
  assign acc_s   = in_valid && in_ready_q;
  assign word_s  = acc_s && (beat_cnt_q == 2'd3);
  assign last_s  = word_s && (waddr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_req) state_d = LOAD; else state_d = IDLE;
      LOAD:    if (last_s)   state_d = DONE; else state_d = LOAD;
      DONE:    if (load_req) state_d = LOAD; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d == LOAD);
    alg_start_d = last_s;
  end

  // The final word holds waddr so the address never wraps back onto word 0.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    waddr_d      = waddr_q;
    words_done_d = words_done_q;
    pack_d       = pack_q;
    if (start_s) begin
      beat_cnt_d   = 2'd0;
      waddr_d      = '0;
      words_done_d = '0;
    end else if (acc_s) begin
      beat_cnt_d = beat_cnt_q + 2'd1;
      case (beat_cnt_q)
        2'd0:    pack_d[31:0]  = in_data;
        2'd1:    pack_d[63:32] = in_data;
        2'd2:    pack_d[95:64] = in_data;
        default: pack_d        = pack_q;
      endcase
      if (word_s) begin
        words_done_d = words_done_q + {{ADDR_W{1'b0}}, 1'b1};
        if (last_s) begin
          waddr_d = waddr_q;
        end else begin
          waddr_d = waddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end else begin
        words_done_d = words_done_q;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q   <= 2'd0;
      waddr_q      <= '0;
      words_done_q <= '0;
      pack_q       <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      alg_start_q  <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      waddr_q      <= waddr_d;
      words_done_q <= words_done_d;
      pack_q       <= pack_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      alg_start_q  <= alg_start_d;
    end
  end

  epu_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (word_s),
    .waddr (waddr_q),
    .wdata ({in_data, pack_q}),
    .re    (read),
    .raddr (addr),
    .rdata (data_read)
  );

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign alg_start  = alg_start_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_epu_alg_buf.sv
// Randomized bench for epu_alg_buf: read responses checked by a queue-fed monitor
// against a word-level memory model built from the beat stream.
module tb_epu_alg_buf;

  localparam int BN     = 1;
  localparam int AW     = 12;
  localparam int DEPTH  = 16 * BN;
  localparam int NBEATS = 4 * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          read = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          in_ready, alg_start, busy;
  logic [127:0]  data_read;
  logic [AW:0]   words_done;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit chk = 1'b0;
  bit chk_p = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] model[DEPTH];
  logic [31:0]  beats[NBEATS];

  epu_alg_buf #(.BLOCK_NUM(BN), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .read(read), .addr(addr), .data_read(data_read),
    .alg_start(alg_start), .busy(busy), .words_done(words_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Monitor: a read issued before an edge is compared at the following negedge.
  always @(posedge clk) chk_p <= chk;

  always @(negedge clk) begin
    logic [127:0] e;
    if (alg_start) pulses++;
    if (chk_p) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: got %h, no expected entry", data_read);
      end else begin
        e = exp_q.pop_front();
        if (data_read !== e) begin
          errors++;
          $display("FAIL rd_data: got %h want %h", data_read, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
    read = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic issue_read(input bit en, input int a);
    read = en;
    addr = a[AW-1:0];
    chk = 1'b1;
    if (en && a < DEPTH) exp_q.push_back(model[a]);
    else exp_q.push_back(128'd0);
  endtask

  task automatic fill(input bit rnd, input bit gaps, input bit collide, input int stop_at);
    load_req = 1'b1;
    tick();
    for (int i = 0; i < stop_at; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          tick();
        end
      end
      beats[i] = rnd ? $urandom : i;
      in_valid = 1'b1;
      in_data = beats[i];
      if (gaps && i == 20) load_req = 1'b1;
      if (collide && (i == 15 || i == 16)) issue_read(1'b1, 3);
      tick();
      if (i % 4 == 3) model[i/4] = {beats[i], beats[i-1], beats[i-2], beats[i-3]};
    end
    in_valid = 1'b0;
  endtask

  task automatic full_done(input int exp_pulses);
    check("start_high", alg_start, 1'b1);
    check("words_done_full", words_done, DEPTH);
    check("ready_low_done", in_ready, 1'b0);
    check("busy_low_done", busy, 1'b0);
    tick();
    check("start_low", alg_start, 1'b0);
    check("pulse_count", pulses, exp_pulses);
  endtask

  task automatic read_all();
    for (int w = 0; w < DEPTH; w++) begin
      issue_read(1'b1, w);
      tick();
    end
    tick();
  endtask

  initial begin
    // Reset and idle behaviour
    #20 rst = 1'b0;
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", alg_start, 1'b0);
    check("rst_words", words_done, 0);
    check("rst_data", data_read, 128'd0);
    in_valid = 1'b1;
    in_data = 32'hdead_beef;
    repeat (5) begin
      tick();
      check("idle_ready", in_ready, 1'b0);
      check("idle_words", words_done, 0);
    end
    in_valid = 1'b0;
    check("idle_pulses", pulses, 0);

    // Basic back-to-back fill
    fill(1'b0, 1'b0, 1'b0, NBEATS);
    full_done(1);
    read = 1'b1;
    addr = '0;
    chk = 1'b1;
    exp_q.push_back(128'h00000003_00000002_00000001_00000000);
    tick();
    tick();

    // Fill with gaps and a load_req that must be ignored mid-fill
    fill(1'b0, 1'b1, 1'b0, NBEATS);
    full_done(2);
    read_all();

    // Read latency, read low, out-of-range
    issue_read(1'b1, 5); tick();
    issue_read(1'b0, 5); tick();
    issue_read(1'b1, 5); tick();
    issue_read(1'b1, DEPTH); tick();
    tick();

    // Random data with read/write collision on word 3
    fill(1'b1, 1'b0, 1'b1, NBEATS);
    full_done(3);
    read_all();

    // Reset in the middle of a fill
    fill(1'b1, 1'b0, 1'b0, 10);
    rst = 1'b1;
    #1;
    check("mid_rst_words", words_done, 0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_start", alg_start, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_ready", in_ready, 1'b0);
    check("post_rst_pulses", pulses, 3);
    read_all();
    fill(1'b1, 1'b1, 1'b0, NBEATS);
    full_done(4);
    read_all();

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
